compressed_word_packer: RTL

Downstream of the 256-bit compressor stage. Takes its variable-length compressed output (a 256-bit word plus a 16-bit tag carrying byte length and end-of-block) and packs the valid bytes contiguously into dense 256-bit beats. The beats go to the output FIFO/DMA, which uses a valid/ready handshake. A last-flagged input flushes the partial beat with zero padding.

---
 rtl/compressed_word_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/compressed_word_packer.sv
// Packs variable-length compressor words (left-justified bytes + length/last tag) into dense 256-bit beats.
// Optional PACKER_STATS_EN adds beat/byte counters (stat_beats, stat_bytes).
module compressed_word_packer #(
    parameter int DATA_W = 256,
    parameter int TAG_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_bytes,
    output logic              out_last
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_bytes
`endif
);
    localparam int RES_W = DATA_W - 8;
    localparam int CAT_W = 2 * DATA_W - 8;

    typedef enum logic {ACCEPT, FLUSH} state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [5:0]        bytes;
        logic              last;
    } beat_t;

    state_t             state_q, state_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [4:0]         fill_q, fill_d;
    beat_t              beat_q, beat_d;

    logic [5:0]         len;
    logic               in_last;
    logic               out_free;
    logic               accept;
    logic [DATA_W-1:0]  in_mask;
    logic [DATA_W-1:0]  in_bytes;
    logic [CAT_W-1:0]   cat;
    logic [5:0]         total;
    logic [8:0]         unused_tag_bits;

    assign unused_tag_bits = in_tag[TAG_W-2:6];

    assign len      = (in_tag[5:0] > 6'd32) ? 6'd32 : in_tag[5:0];
    assign in_last  = in_tag[TAG_W-1];
    assign out_free = !beat_q.valid || out_ready;
    assign in_ready = reset && (state_q == ACCEPT) && out_free;
    assign accept   = in_valid && in_ready;

    // Shift by 256 yields zero, so len==32 keeps every byte.
    assign in_mask  = ~({DATA_W{1'b1}} >> {len, 3'b000});
    assign in_bytes = in_data & in_mask;

    // Residue bytes past fill are kept zero, so an OR merges the new bytes in place.
    assign cat   = {res_q, {DATA_W{1'b0}}} | ({in_bytes, {RES_W{1'b0}}} >> {fill_q, 3'b000});
    assign total = {1'b0, fill_q} + len;

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        fill_d       = fill_q;
        beat_d       = beat_q;
        beat_d.valid = beat_q.valid && !out_ready;
        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    if (total >= 6'd32) begin
                        beat_d.valid = 1'b1;
                        beat_d.data  = cat[CAT_W-1 -: DATA_W];
                        beat_d.bytes = 6'd32;
                        beat_d.last  = in_last && (total == 6'd32);
                        res_d        = cat[RES_W-1:0];
                        fill_d       = total[4:0];
                        if (in_last && total != 6'd32)
                            state_d = FLUSH;
                    end else if (in_last) begin
                        if (total != 6'd0) begin
                            beat_d.valid = 1'b1;
                            beat_d.data  = cat[CAT_W-1 -: DATA_W];
                            beat_d.bytes = total;
                            beat_d.last  = 1'b1;
                        end
                        res_d  = '0;
                        fill_d = 5'd0;
                    end else begin
                        res_d  = cat[CAT_W-1 -: RES_W];
                        fill_d = total[4:0];
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    beat_d.valid = 1'b1;
                    beat_d.data  = {res_q, 8'h00};
                    beat_d.bytes = {1'b0, fill_q};
                    beat_d.last  = 1'b1;
                    res_d        = '0;
                    fill_d       = 5'd0;
                    state_d      = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCEPT;
            res_q   <= '0;
            fill_q  <= 5'd0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            fill_q  <= fill_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid = beat_q.valid;
    assign out_data  = beat_q.data;
    assign out_bytes = beat_q.bytes;
    assign out_last  = beat_q.last;

`ifdef PACKER_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_bytes_q, stat_bytes_d;

    always_comb begin
        stat_beats_d = stat_beats_q + {31'd0, beat_q.valid && out_ready};
        stat_bytes_d = stat_bytes_q + (accept ? {26'd0, len} : 32'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_beats_q <= 32'd0;
            stat_bytes_q <= 32'd0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_bytes_q <= stat_bytes_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_bytes = stat_bytes_q;
`endif

endmodule
